// File: rtl/ysyx_220053_cla_pkg.sv
// Shared constants, stage-count helper and per-stage register record for the pipelined CLA.
// The flag fields of the record exist only when YSYX_220053_CLA_FLAGS_EN is defined.
package ysyx_220053_cla_pkg;

  localparam logic CLA_ADD = 1'b0;
  localparam logic CLA_SUB = 1'b1;

  function automatic int cla_stages(input int width, input int seg);
    return width / seg;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
`ifdef YSYX_220053_CLA_FLAGS_EN
    logic xMsb;
    logic yMsb;
    logic zero;
    logic ovf;
`endif
  } cla_stage_t;

endpackage

// File: rtl/ysyx_220053_cla_seg.sv
// Combinational SEG-bit adder segment built from 4-bit lookahead groups; exports segment P/G.
module ysyx_220053_cla_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] x_i,
  input  logic [SEG-1:0] y_i,
  input  logic           cin_i,
  output logic [SEG-1:0] f_o,
  output logic           cout_o,
  output logic           p_o,
  output logic           g_o
);

  localparam int GROUPS = SEG / 4;

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG-1:0] c;
  logic           grpP;
  logic           grpG;
  logic           carry;
  logic           segP;
  logic           segG;

  // Bit carries are resolved inside each 4-bit group; group carries chain between groups.
  always_comb begin
    p     = x_i ^ y_i;
    g     = x_i & y_i;
    c     = '0;
    carry = cin_i;
    grpP  = 1'b0;
    grpG  = 1'b0;
    segP  = 1'b1;
    segG  = 1'b0;
    for (int i = 0; i < GROUPS; i++) begin
      c[4*i]   = carry;
      c[4*i+1] = g[4*i] | (p[4*i] & carry);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & carry);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & carry);
      grpP  = &p[4*i +: 4];
      grpG  = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      carry = grpG | (grpP & carry);
      segG  = grpG | (grpP & segG);
      segP  = segP & grpP;
    end
  end

  assign f_o    = p ^ c;
  assign cout_o = carry;
  assign p_o    = segP;
  assign g_o    = segG;

endmodule

// File: rtl/ysyx_220053_pipe_cla.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit segment per stage, valid/ready on both sides.
// Define YSYX_220053_CLA_FLAGS_EN to build the signed-overflow and zero flags.
module ysyx_220053_pipe_cla
  import ysyx_220053_cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG   = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = cla_stages(WIDTH, SEG);
  localparam int MSB    = WIDTH - 1;

  logic             en;
  logic             subMode;
  logic [WIDTH-1:0] yIn;

  cla_stage_t       srcSt  [STAGES];
  cla_stage_t       st_d   [STAGES];
  cla_stage_t       st_q   [STAGES];
  logic [WIDTH-1:0] srcX   [STAGES];
  logic [WIDTH-1:0] srcY   [STAGES];
  logic [WIDTH-1:0] srcF   [STAGES];
  logic [WIDTH-1:0] f_d    [STAGES];
  logic [WIDTH-1:0] x_q    [STAGES];
  logic [WIDTH-1:0] y_q    [STAGES];
  logic [WIDTH-1:0] f_q    [STAGES];
  logic [TAG_W-1:0] srcTag [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];
  logic [SEG-1:0]   segF   [STAGES];
  logic             segCout[STAGES];
  logic             segP   [STAGES];
  logic             segG   [STAGES];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign subMode  = (in_sub == CLA_SUB);
  assign yIn      = subMode ? ~in_y : in_y;

  // Stage 0 is fed from the ports (y already inverted); later stages from the previous register.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        srcSt[k]       = '0;
        srcSt[k].valid = in_valid;
        srcSt[k].carry = subMode ? 1'b1 : in_cin;
`ifdef YSYX_220053_CLA_FLAGS_EN
        srcSt[k].xMsb  = in_x[MSB];
        srcSt[k].yMsb  = yIn[MSB];
        srcSt[k].zero  = 1'b1;
`endif
        srcX[k]   = in_x;
        srcY[k]   = yIn;
        srcF[k]   = '0;
        srcTag[k] = in_tag;
      end else begin
        srcSt[k]  = st_q[(k > 0) ? k - 1 : 0];
        srcX[k]   = x_q[(k > 0) ? k - 1 : 0];
        srcY[k]   = y_q[(k > 0) ? k - 1 : 0];
        srcF[k]   = f_q[(k > 0) ? k - 1 : 0];
        srcTag[k] = tag_q[(k > 0) ? k - 1 : 0];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    ysyx_220053_cla_seg #(.SEG(SEG)) u_seg (
      .x_i   (srcX[k][k*SEG +: SEG]),
      .y_i   (srcY[k][k*SEG +: SEG]),
      .cin_i (srcSt[k].carry),
      .f_o   (segF[k]),
      .cout_o(segCout[k]),
      .p_o   (segP[k]),
      .g_o   (segG[k])
    );
  end

  // Inter-stage carries come from segment P/G; the top segment's carry-out becomes out_cout.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k]       = srcSt[k];
      st_d[k].carry = (k == STAGES - 1) ? segCout[k]
                                        : (segG[k] | (segP[k] & srcSt[k].carry));
`ifdef YSYX_220053_CLA_FLAGS_EN
      st_d[k].zero  = srcSt[k].zero & ~|segF[k];
      st_d[k].ovf   = (srcSt[k].xMsb == srcSt[k].yMsb) && (segF[k][SEG-1] != srcSt[k].xMsb);
`endif
      f_d[k]                = srcF[k];
      f_d[k][k*SEG +: SEG]  = segF[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k]  <= '0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        f_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k]  <= st_d[k];
        x_q[k]   <= srcX[k];
        y_q[k]   <= srcY[k];
        f_q[k]   <= f_d[k];
        tag_q[k] <= srcTag[k];
      end
    end
  end

  assign out_valid = st_q[STAGES-1].valid;
  assign out_cout  = st_q[STAGES-1].carry;
  assign out_f     = f_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
`ifdef YSYX_220053_CLA_FLAGS_EN
  assign out_ovf   = st_q[STAGES-1].ovf;
  assign out_zero  = st_q[STAGES-1].zero;
`else
  assign out_ovf   = 1'b0;
  assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_220053_pipe_cla.sv
// Scoreboard bench for ysyx_220053_pipe_cla (64-bit, 16-bit segments); follows YSYX_220053_CLA_FLAGS_EN.
module tb_ysyx_220053_pipe_cla;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic [63:0] in_y;
  logic        in_sub;
  logic        in_cin;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_f;
  logic        out_cout;
  logic [4:0]  out_tag;
  logic        out_ovf;
  logic        out_zero;

  typedef struct {
    logic [63:0] f;
    logic        cout;
    logic [4:0]  tag;
    logic        ovf;
    logic        zero;
    int          issueCyc;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   strictLatency = 1'b0;

  // Directed vectors with hand-computed results (flags as in the flags build).
  logic [63:0] dX   [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h5,
                            64'hDEAD_BEEF_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3,
                            64'h0000_0000_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0};
  logic [63:0] dY   [8] = '{64'h1, 64'h1, 64'h3, 64'hDEAD_BEEF_0000_0001, 64'h1, 64'h5,
                            64'h1, 64'h1111_1111_1111_1111};
  logic        dSub [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        dCin [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [63:0] dF   [8] = '{64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 64'h0,
                            64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE,
                            64'h0000_0001_0000_0000, 64'h2345_6789_ABCD_F002};
  logic        dCout[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        dOvf [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        dZero[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  ysyx_220053_pipe_cla #(.WIDTH(64), .SEG(16), .TAG_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_sub   (in_sub),
    .in_cin   (in_cin),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_f    (out_f),
    .out_cout (out_cout),
    .out_tag  (out_tag),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic exp_t directedExp(input int i, input logic [4:0] tag);
    exp_t e;
    e.f        = dF[i];
    e.cout     = dCout[i];
    e.tag      = tag;
`ifdef YSYX_220053_CLA_FLAGS_EN
    e.ovf      = dOvf[i];
    e.zero     = dZero[i];
`else
    e.ovf      = 1'b0;
    e.zero     = 1'b0;
`endif
    e.issueCyc = 0;
    return e;
  endfunction

  function automatic exp_t modelExp(input logic [63:0] x, input logic [63:0] y,
                                    input logic sub, input logic cin, input logic [4:0] tag);
    exp_t        e;
    logic [64:0] s;
    logic [63:0] yp;
    yp         = sub ? ~y : y;
    s          = {1'b0, x} + {1'b0, yp} + {64'd0, (sub ? 1'b1 : cin)};
    e.f        = s[63:0];
    e.cout     = s[64];
    e.tag      = tag;
`ifdef YSYX_220053_CLA_FLAGS_EN
    e.ovf      = (x[63] == yp[63]) && (s[63] != x[63]);
    e.zero     = (s[63:0] == 64'd0);
`else
    e.ovf      = 1'b0;
    e.zero     = 1'b0;
`endif
    e.issueCyc = 0;
    return e;
  endfunction

  // Presents one op and returns at the negedge before its accept edge; waits counts stalled cycles.
  task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y, input logic sub,
                               input logic cin, input logic [4:0] tag, input exp_t e, output int waits);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_sub   = sub;
    in_cin   = cin;
    in_tag   = tag;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        total++;
        bad++;
        $display("[TB] FAIL accept_timeout: in_ready stayed %0d, expected 1", in_ready);
        break;
      end
    end
    if (waits <= 100) begin
      e.issueCyc = cyc;
      expQ.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", expQ.size());
    end
  endtask

  // Monitor: pops and compares every result the DUT hands over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got tag %0d f %h, expected no result", out_tag, out_f);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_f", out_f, e.f);
          checkOutput("out_cout", 64'(out_cout), 64'(e.cout));
          checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
          checkOutput("out_ovf", 64'(out_ovf), 64'(e.ovf));
          checkOutput("out_zero", 64'(out_zero), 64'(e.zero));
          if (strictLatency) checkOutput("latency", 64'(cyc - e.issueCyc), 64'(STAGES));
        end
      end
    end
  end

  initial begin
    int          waits;
    bit          done;
    logic [63:0] heldF;
    logic [4:0]  heldTag;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    done      = 1'b0;

    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_f", out_f, 64'd0);
    checkOutput("reset_out_cout", 64'(out_cout), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("reset_out_zero", 64'(out_zero), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single op: full carry propagation, out_valid exactly four cycles after presentation.
    strictLatency = 1'b1;
    applyStimulus(dX[0], dY[0], dSub[0], dCin[0], 5'd9, directedExp(0, 5'd9), waits);
    idle();
    for (int i = 1; i <= STAGES; i++) begin
      @(negedge clk);
      checkOutput("latency_out_valid", 64'(out_valid), (i == STAGES) ? 64'd1 : 64'd0);
    end
    waitDrain();

    applyStimulus(dX[1], dY[1], dSub[1], dCin[1], 5'd10, directedExp(1, 5'd10), waits);
    idle();
    waitDrain();

    // Back-to-back stream of all directed vectors, tags 0..7.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(dX[i], dY[i], dSub[i], dCin[i], 5'(i), directedExp(i, 5'(i)), waits);
      checkOutput("stream_stall_cycles", 64'(waits), 64'd0);
    end
    idle();
    waitDrain();
    strictLatency = 1'b0;

    // Backpressure on a full pipe.
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(dX[i], dY[i], dSub[i], dCin[i], 5'(16 + i), directedExp(i, 5'(16 + i)), waits);
        idle();
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        checkOutput("bp_pipe_filled", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        heldF     = '0;
        heldTag   = '0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
          if (s == 0) begin
            heldF   = out_f;
            heldTag = out_tag;
          end else begin
            checkOutput("bp_out_f_stable", out_f, heldF);
            checkOutput("bp_out_tag_stable", 64'(out_tag), 64'(heldTag));
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);
      end
    join
    waitDrain();

    // Reset with three ops in flight.
    for (int i = 5; i < 8; i++)
      applyStimulus(dX[i], dY[i], dSub[i], dCin[i], 5'(i - 4), directedExp(i, 5'(i - 4)), waits);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_f", out_f, 64'd0);
    checkOutput("midrst_out_cout", 64'(out_cout), 64'd0);
    checkOutput("midrst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    expQ.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clk);
      checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
    end
    applyStimulus(64'd5, 64'd3, 1'b1, 1'b0, 5'd7, directedExp(2, 5'd7), waits);
    idle();
    waitDrain();

    // Random ops with random input gaps and random consumer stalls.
    fork
      begin
        logic [63:0] x;
        logic [63:0] y;
        logic        sub;
        logic        cin;
        int          gap;
        for (int n = 0; n < 300; n++) begin
          x   = {$urandom, $urandom};
          case ($urandom_range(0, 3))
            0:       y = ~x;
            1:       y = x;
            default: y = {$urandom, $urandom};
          endcase
          sub = 1'($urandom_range(0, 1));
          cin = 1'($urandom_range(0, 1));
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) idle();
          applyStimulus(x, y, sub, cin, 5'(n), modelExp(x, y, sub, cin, 5'(n)), waits);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    waitDrain();

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
